data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder for an RV32I load/store port.
// A request is accepted in IDLE, waits LATENCY cycles in WAIT, then the
// access is executed and the response is held in RESP until it is taken.
// The memory word is read when the request is accepted, so the array only
// needs a registered read port. The store is written back as a merged full
// word on the executing edge.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic [31:0]   mem_array [DEPTH_WORDS];
  logic [31:0]   rd_word_q;

  logic          accept;
  logic          execute;
  logic          mem_we;
  logic [1:0]    lo;
  logic          access_err;
  logic [31:0]   shifted;
  logic [31:0]   load_data;
  logic [31:0]   wpos;
  logic [3:0]    be;
  logic [31:0]   merged;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign accept  = rst_n && req_valid && (state_q == IDLE);
  assign execute = (state_q == WAIT) && (cnt_q == 4'd0);
  assign lo      = addr_q[1:0];

  // Misalignment / illegal encoding check on the captured request
  always_comb begin
    access_err = 1'b0;
    case (funct3_q)
      3'b000:  access_err = 1'b0;
      3'b001:  access_err = lo[0];
      3'b010:  access_err = (lo != 2'b00);
      3'b100:  access_err = write_q;
      3'b101:  access_err = write_q || lo[0];
      default: access_err = 1'b1;
    endcase
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    shifted   = rd_word_q >> {lo, 3'b000};
    load_data = 32'd0;
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = rd_word_q;
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  // Store byte enables and lane-aligned store data
  always_comb begin
    wpos = wdata_q << {lo, 3'b000};
    be   = 4'b0000;
    case (funct3_q)
      3'b000:  be = 4'b0001 << lo;
      3'b001:  be = 4'b0011 << lo;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = be[gi] ? wpos[gi*8 +: 8] : rd_word_q[gi*8 +: 8];
    end
  endgenerate

  // Reset on the executing edge discards the store
  assign mem_we = rst_n && execute && write_q && !access_err;

  // Next-state and registered-output computation for the FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          addr_d   = req_addr[AW+1:0];
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          cnt_d    = 4'(LATENCY - 1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          resp_valid_d = 1'b1;
          resp_err_d   = access_err;
          resp_rdata_d = (access_err || write_q) ? 32'd0 : load_data;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and response registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Captured request fields need no reset; they are only used after acceptance
  always_ff @(posedge clk) begin
    write_q  <= write_d;
    addr_q   <= addr_d;
    funct3_q <= funct3_d;
    wdata_q  <= wdata_d;
  end

  // Memory array: registered read at acceptance, merged word write at execution
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_word_q <= mem_array[req_addr[AW+1:2]];
    end
    if (mem_we) begin
      mem_array[addr_q[AW+1:2]] <= merged;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (defaults: 256 words,
// LATENCY 2). Inputs change after the falling edge or 1 ns after the rising
// edge; outputs are sampled 1 ns after the rising edge.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_pass   = 0;

  data_mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-16s got=0x%08h exp=0x%08h ok", tag, got, exp);
    end else begin
      $display("FAIL %-16s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
  endtask

  // One full transaction with resp_ready=1; lat counts edges from acceptance
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    @(negedge clk);
    drive(wr, addr, f3, wd);
    resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = -1;
    rd  = 32'hxxxxxxxx;
    er  = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        lat = i;
        rd  = resp_rdata;
        er  = resp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op_chk(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(wr, addr, f3, wd, rd, er, lat);
    check({tag, "_rd"}, rd, exp_rd);
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    check({tag, "_lat"}, 32'(lat), 32'd2);
  endtask

  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_seen"}, {31'd0, resp_valid}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    resp_ready = 1'b0;
    drive(1'b1, 32'h40, 3'b010, 32'h0BAD0BAD);
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_accept", {31'd0, resp_valid}, 32'd0);

    // Word store then load
    op_chk("sw_10", 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0);
    op_chk("lw_10", 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);

    // Extension
    op_chk("lb_13", 1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0);
    op_chk("lbu_13", 1'b0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 1'b0);
    op_chk("lh_12", 1'b0, 32'h12, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0);
    op_chk("lhu_10", 1'b0, 32'h10, 3'b101, 32'h0, 32'h0000BEEF, 1'b0);

    // Partial stores
    op_chk("sb_11", 1'b1, 32'h11, 3'b000, 32'hFFFFFF55, 32'h0, 1'b0);
    op_chk("lw_sb", 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0);
    op_chk("sh_12", 1'b1, 32'h12, 3'b001, 32'hFFFF1234, 32'h0, 1'b0);
    op_chk("lw_sh", 1'b0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 1'b0);

    // Errors
    op_chk("lw_11_err", 1'b0, 32'h11, 3'b010, 32'h0, 32'h0, 1'b1);
    op_chk("sh_13_err", 1'b1, 32'h13, 3'b001, 32'h0000AAAA, 32'h0, 1'b1);
    op_chk("sbu_err", 1'b1, 32'h10, 3'b100, 32'h00000011, 32'h0, 1'b1);
    op_chk("f3_011_err", 1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
    op_chk("lw_after_err", 1'b0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 1'b0);

    // Backpressure: response held for 5 cycles
    @(negedge clk);
    drive(1'b0, 32'h10, 3'b010, 32'h0);
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_resp("bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_valid_%0d", i), {31'd0, resp_valid}, 32'd1);
      check($sformatf("bp_rdata_%0d", i), resp_rdata, 32'h123455EF);
      check($sformatf("bp_ready_%0d", i), {31'd0, req_ready}, 32'd0);
    end
    // New request presented during the handshake must wait one edge
    @(negedge clk);
    resp_ready = 1'b1;
    drive(1'b0, 32'h12, 3'b101, 32'h0);
    @(posedge clk);
    #1;
    check("hs_valid_drop", {31'd0, resp_valid}, 32'd0);
    check("hs_no_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("hs_accepted", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("hs_wait1", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("hs_resp", {31'd0, resp_valid}, 32'd1);
    check("hs_rdata", resp_rdata, 32'h00001234);
    @(posedge clk);
    #1;

    // Address wrap modulo 1 KiB
    op_chk("sw_400", 1'b1, 32'h400, 3'b010, 32'hA5A5A5A5, 32'h0, 1'b0);
    op_chk("lw_000", 1'b0, 32'h000, 3'b010, 32'h0, 32'hA5A5A5A5, 1'b0);

    // Reset during WAIT discards the store
    op_chk("sw_20", 1'b1, 32'h20, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h20, 3'b010, 32'h00000001);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    check("rstw_req_ready", {31'd0, req_ready}, 32'd1);
    check("rstw_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rstw_no_resp", {31'd0, resp_valid}, 32'd0);
    op_chk("lw_20", 1'b0, 32'h20, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0);

    // Reset during RESP drops the response but keeps the store
    @(negedge clk);
    drive(1'b1, 32'h30, 3'b010, 32'h00000077);
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_resp("rstr");
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstr_valid", {31'd0, resp_valid}, 32'd0);
    check("rstr_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    op_chk("lw_30", 1'b0, 32'h30, 3'b010, 32'h0, 32'h00000077, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
